yapay_zeka_hizlandirici: RTL and testbench
==========================================

# yapay_zeka_hizlandirici

- Convolution/dot-product sequencer for the core's custom AI instructions; the execute stage drives it.
- Holds two operand buffers:
  - weights (W), filled by `YZH_LD_W`;
  - inputs (X), filled by `YZH_LD_X`.
- On `YZH_RUN` it streams W[i]/X[i] pairs, one per cycle, to the shared external multiply-accumulate unit.
- It pulses that unit's accumulator reset before the stream starts and pulses `bitti_o` when the command completes.

## Interface
- `DERINLIK`, 16: entries per buffer (power of two, ≥2).
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: synchronous, active-low reset.
- `ddb_durdur_i` in 1: pipeline stall; freezes all state while high.
- `kontrol_i` in 3: command code, sampled with `basla_i`.
- `basla_i` in 1: command valid.
- `rs2_en_i` in 1: for LD commands, `deger2_i` is also valid.
- `deger1_i` in 32: rs1 operand.
- `deger2_i` in 32: rs2 operand.
- `carpma_rst_o` out 1: one-cycle accumulator clear to the MAC.
- `bitti_o` out 1: one-cycle command-complete pulse.
- `carp_deger1_o` out 32: multiplier operand 1, the W element.
- `carp_deger2_o` out 32: multiplier operand 2, the X element.

## Operation
- Command codes (`tanimlamalar.vh`):
  - `YZH_LD_W`=3'b001
  - `YZH_CLR_W`=3'b010
  - `YZH_LD_X`=3'b011
  - `YZH_CLR_X`=3'b100
  - `YZH_RUN`=3'b101
  - All other codes are NOP: accepted, `bitti_o` pulses, no state change.
- FSM states: BOSTA, TEMIZLE, CALIS, BITTI. A command is accepted only in BOSTA with `basla_i`=1 and `ddb_durdur_i`=0.
- **LD_W / LD_X**
  - Write `deger1_i` at the buffer's pointer `wp`/`xp`.
  - If `rs2_en_i`=1, also write `deger2_i` at pointer+1.
  - Pointer advances by the number of words written.
  - Writes beyond `DERINLIK` are dropped; the pointer saturates at `DERINLIK` (full).
  - FSM goes to BITTI.
- **CLR_W / CLR_X**: pointer goes to 0. Buffer contents need not be cleared. FSM goes to BITTI.
- **RUN**
  - Length `L` = min(`wp`, `xp`).
  - FSM goes to TEMIZLE, then CALIS for `L` cycles, emitting pair i=0..L-1. It skips CALIS if `L`=0.
  - Then BITTI.
  - Buffers and pointers are unchanged by RUN.
- BITTI: `bitti_o`=1 for one cycle, then back to BOSTA. `basla_i` is ignored in BITTI, so a held `basla_i` re-issues the command at most once every 2 cycles.
- `carp_deger*_o` are 0 outside CALIS.
- `carpma_rst_o` is 1 only in TEMIZLE.
- All outputs are registered.

## Timing
- Reset: state BOSTA, `wp`=`xp`=0, all outputs 0. Reset asserted mid-RUN aborts immediately: no `bitti_o`, buffers are lost.
- LD/CLR/NOP accepted at edge T: `bitti_o`=1 during cycle T+1. A LD immediately followed by RUN sees the new data.
- RUN accepted at T:
  - `carpma_rst_o`=1 during T+1.
  - Pair i on the outputs during T+2+i.
  - `bitti_o`=1 during T+2+L.
  - `L`=0 gives `bitti_o` at T+2.
- Stall: while `ddb_durdur_i`=1, the FSM, pointers, buffers and all outputs hold their values, including a pending `bitti_o` or `carpma_rst_o` pulse. A held pulse is stretched and completes after the stall.
- No new command is taken while busy. Upstream must hold `basla_i` until `bitti_o`.

## Configuration
- `YZH_CIFT_YUKLEME_EN` defined: `rs2_en_i` enables two-word loads as above.
- Undefined:
  - `rs2_en_i` is ignored.
  - Every LD writes only `deger1_i` and advances the pointer by 1.
  - The second write port is removed.

## Test plan
- **Reset:** `rst_i`=0 for 2 cycles → all outputs 0. RUN then gives `carpma_rst_o` pulse and `bitti_o` two cycles after accept, with no operand cycles.
- **Load and run:**
  - LD_W (100,5, `rs2_en_i`=1), then LD_X (3,7, `rs2_en_i`=1), then RUN.
  - Outputs (100,3) then (5,7) on consecutive cycles after one `carpma_rst_o` cycle, then `bitti_o`.
- **Clear and mismatched lengths:**
  - After the previous scenario, CLR_X then RUN: zero-length run, `bitti_o` at T+2.
  - Then LD_X 9 (`rs2_en_i`=0) and RUN: single pair (100,9).
- **Saturation:**
  - Issue 10 two-word LD_W with `DERINLIK`=16 → `wp`=16.
  - 16 X words loaded, then RUN: exactly 16 pairs.
  - Words 17-20 never appear.
- **Stall:** assert `ddb_durdur_i` for 3 cycles in the middle of a 4-pair RUN → the current pair is held 4 cycles total, the sequence stays in order, and `bitti_o` is delayed by 3.
- **Held `basla_i`** with RUN constantly asserted → repeated runs, each framed by `carpma_rst_o` … `bitti_o`, with no overlap.

Source files
------------

// File: rtl/yapay_zeka_hizlandirici.sv
// Dot-product sequencer: W/X operand buffers streamed pairwise to an external MAC.
// Optional macro YZH_CIFT_YUKLEME_EN enables two-word loads via rs2_en_i/deger2_i.
`timescale 1ns/1ps
module yapay_zeka_hizlandirici #(
    parameter int DERINLIK = 16,
    parameter int DATA_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ddb_durdur_i,
    input  logic [2:0]        kontrol_i,
    input  logic              basla_i,
    input  logic              rs2_en_i,
    input  logic [DATA_W-1:0] deger1_i,
    input  logic [DATA_W-1:0] deger2_i,
    output logic              carpma_rst_o,
    output logic              bitti_o,
    output logic [DATA_W-1:0] carp_deger1_o,
    output logic [DATA_W-1:0] carp_deger2_o
);
    localparam int AW = $clog2(DERINLIK);
    localparam int PW = AW + 1;
    typedef logic [PW-1:0] ptr_t;
    localparam ptr_t DOLU = ptr_t'(DERINLIK);

    localparam logic [2:0] YZH_LD_W  = 3'b001;
    localparam logic [2:0] YZH_CLR_W = 3'b010;
    localparam logic [2:0] YZH_LD_X  = 3'b011;
    localparam logic [2:0] YZH_CLR_X = 3'b100;
    localparam logic [2:0] YZH_RUN   = 3'b101;

    typedef enum logic [1:0] {BOSTA, TEMIZLE, CALIS, BITTI} durum_t;

    durum_t            durum_q, durum_d;
    ptr_t              wp_q, wp_d, xp_q, xp_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] w_buf_q [DERINLIK];
    logic [DATA_W-1:0] w_buf_d [DERINLIK];
    logic [DATA_W-1:0] x_buf_q [DERINLIK];
    logic [DATA_W-1:0] x_buf_d [DERINLIK];
    logic              carpma_rst_q, carpma_rst_d;
    logic              bitti_q, bitti_d;
    logic [DATA_W-1:0] carp1_q, carp1_d, carp2_q, carp2_d;
    ptr_t              uzunluk;
    logic              iki;

`ifdef YZH_CIFT_YUKLEME_EN
    ptr_t wp_ek, xp_ek;
    assign iki   = rs2_en_i;
    assign wp_ek = wp_q + ptr_t'(1);
    assign xp_ek = xp_q + ptr_t'(1);
`else
    logic unused_ok;
    assign iki       = 1'b0;
    assign unused_ok = ^{rs2_en_i, deger2_i};
`endif

    // Pointer advance saturating at DOLU so overflowing writes are dropped.
    function automatic ptr_t ptr_ilerle(input ptr_t p, input logic cift);
        ptr_t n;
        n = p + (cift ? ptr_t'(2) : ptr_t'(1));
        return (n > DOLU) ? DOLU : n;
    endfunction

    assign uzunluk = (wp_q < xp_q) ? wp_q : xp_q;

    always_comb begin
        durum_d      = durum_q;
        wp_d         = wp_q;
        xp_d         = xp_q;
        idx_d        = idx_q;
        w_buf_d      = w_buf_q;
        x_buf_d      = x_buf_q;
        carpma_rst_d = carpma_rst_q;
        bitti_d      = bitti_q;
        carp1_d      = carp1_q;
        carp2_d      = carp2_q;
        if (!ddb_durdur_i) begin
            case (durum_q)
                BOSTA: begin
                    if (basla_i) begin
                        durum_d = BITTI;
                        case (kontrol_i)
                            YZH_LD_W: begin
                                if (wp_q < DOLU) w_buf_d[wp_q[AW-1:0]] = deger1_i;
`ifdef YZH_CIFT_YUKLEME_EN
                                if (iki && wp_ek < DOLU) w_buf_d[wp_ek[AW-1:0]] = deger2_i;
`endif
                                wp_d = ptr_ilerle(wp_q, iki);
                            end
                            YZH_LD_X: begin
                                if (xp_q < DOLU) x_buf_d[xp_q[AW-1:0]] = deger1_i;
`ifdef YZH_CIFT_YUKLEME_EN
                                if (iki && xp_ek < DOLU) x_buf_d[xp_ek[AW-1:0]] = deger2_i;
`endif
                                xp_d = ptr_ilerle(xp_q, iki);
                            end
                            YZH_CLR_W: wp_d = '0;
                            YZH_CLR_X: xp_d = '0;
                            YZH_RUN:   durum_d = TEMIZLE;
                            default:   durum_d = BITTI;
                        endcase
                    end
                end
                TEMIZLE: begin
                    if (uzunluk == '0) begin
                        durum_d = BITTI;
                    end else begin
                        durum_d = CALIS;
                        idx_d   = '0;
                    end
                end
                CALIS: begin
                    if (ptr_t'(idx_q) + ptr_t'(1) == uzunluk) durum_d = BITTI;
                    else idx_d = idx_q + 1'b1;
                end
                default: durum_d = BOSTA;
            endcase
            // Outputs follow the next state so they are registered yet aligned with it.
            carpma_rst_d = (durum_d == TEMIZLE);
            bitti_d      = (durum_d == BITTI);
            carp1_d      = (durum_d == CALIS) ? w_buf_q[idx_d] : '0;
            carp2_d      = (durum_d == CALIS) ? x_buf_q[idx_d] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            durum_q      <= BOSTA;
            wp_q         <= '0;
            xp_q         <= '0;
            idx_q        <= '0;
            carpma_rst_q <= 1'b0;
            bitti_q      <= 1'b0;
            carp1_q      <= '0;
            carp2_q      <= '0;
        end else begin
            durum_q      <= durum_d;
            wp_q         <= wp_d;
            xp_q         <= xp_d;
            idx_q        <= idx_d;
            carpma_rst_q <= carpma_rst_d;
            bitti_q      <= bitti_d;
            carp1_q      <= carp1_d;
            carp2_q      <= carp2_d;
        end
    end

    always_ff @(posedge clk_i) begin
        w_buf_q <= w_buf_d;
        x_buf_q <= x_buf_d;
    end

    assign carpma_rst_o  = carpma_rst_q;
    assign bitti_o       = bitti_q;
    assign carp_deger1_o = carp1_q;
    assign carp_deger2_o = carp2_q;
endmodule

// File: tb/tb_yapay_zeka_hizlandirici.sv
// Directed bench for yapay_zeka_hizlandirici: command table plus stall, held-start and reset sequences.
`timescale 1ns/1ps
module tb_yapay_zeka_hizlandirici;
`ifdef YZH_CIFT_YUKLEME_EN
    localparam bit CIFT = 1'b1;
`else
    localparam bit CIFT = 1'b0;
`endif
    localparam logic [2:0] LD_W  = 3'b001;
    localparam logic [2:0] CLR_W = 3'b010;
    localparam logic [2:0] LD_X  = 3'b011;
    localparam logic [2:0] CLR_X = 3'b100;
    localparam logic [2:0] RUN   = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ddb = 1'b0;
    logic [2:0]  kontrol = 3'b000;
    logic        basla = 1'b0;
    logic        rs2 = 1'b0;
    logic [31:0] d1 = '0, d2 = '0;
    logic        carpma_rst, bitti;
    logic [31:0] cw, cx;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_w [32];
    logic [31:0] exp_x [32];

    typedef struct {
        logic [2:0]  k;
        logic        r;
        logic [31:0] a, b;
        int          len;
        logic [31:0] w0, x0, w1, x1;
        int          s, n;
    } vek_t;
    vek_t tablo [13];

    yapay_zeka_hizlandirici #(.DERINLIK(16), .DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst_n), .ddb_durdur_i(ddb), .kontrol_i(kontrol),
        .basla_i(basla), .rs2_en_i(rs2), .deger1_i(d1), .deger2_i(d2),
        .carpma_rst_o(carpma_rst), .bitti_o(bitti),
        .carp_deger1_o(cw), .carp_deger2_o(cx)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string ad, input logic [31:0] got, input logic [31:0] beklenen);
        total++;
        if (got !== beklenen) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", ad, got, beklenen);
        end
    endtask

    task automatic dort_kontrol(input string ad, input logic er, input logic eb,
                                input logic [31:0] ew, input logic [31:0] ex);
        cmp({ad, " carpma_rst"}, 32'(carpma_rst), 32'(er));
        cmp({ad, " bitti"}, 32'(bitti), 32'(eb));
        cmp({ad, " w"}, cw, ew);
        cmp({ad, " x"}, cx, ex);
    endtask

    // Issue one command and check every output cycle until the command completes;
    // stall covers the edges ending observed cycles s..s+n-1.
    task automatic yurut(input logic [2:0] k, input logic r, input logic [31:0] a,
                         input logic [31:0] b, input int len, input int s, input int n);
        bit run;
        int son, m;
        logic [31:0] ew, ex;
        run = (k == RUN);
        son = run ? 2 + len : 1;
        @(negedge clk);
        kontrol = k; rs2 = r; d1 = a; d2 = b; basla = 1'b1;
        @(posedge clk); #1;
        basla = 1'b0;
        for (int c = 1; c <= son + n; c++) begin
            m = (n == 0 || c <= s) ? c : ((c <= s + n) ? s : c - n);
            ew = '0; ex = '0;
            if (run && m >= 2 && m < 2 + len) begin
                ew = exp_w[m-2];
                ex = exp_x[m-2];
            end
            dort_kontrol($sformatf("cmd%0d c%0d", k, c), run && m == 1, m == son, ew, ex);
            if (n > 0 && c == s) ddb = 1'b1;
            if (n > 0 && c == s + n) ddb = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tablo[0]  = '{LD_W,  1'b1, 100, 5, 0,             0,   0, 0, 0, 0, 0};
        tablo[1]  = '{LD_X,  1'b1, 3,   7, 0,             0,   0, 0, 0, 0, 0};
        tablo[2]  = '{RUN,   1'b0, 0,   0, (CIFT ? 2 : 1), 100, 3, 5, 7, 0, 0};
        tablo[3]  = '{CLR_X, 1'b0, 0,   0, 0,             0,   0, 0, 0, 0, 0};
        tablo[4]  = '{RUN,   1'b0, 0,   0, 0,             0,   0, 0, 0, 0, 0};
        tablo[5]  = '{LD_X,  1'b0, 9,   0, 0,             0,   0, 0, 0, 0, 0};
        tablo[6]  = '{RUN,   1'b0, 0,   0, 1,             100, 9, 0, 0, 0, 0};
        tablo[7]  = '{3'b000, 1'b0, 0,  0, 0,             0,   0, 0, 0, 0, 0};
        tablo[8]  = '{3'b111, 1'b0, 0,  0, 0,             0,   0, 0, 0, 1, 1};
        tablo[9]  = '{CLR_W, 1'b0, 0,   0, 0,             0,   0, 0, 0, 0, 0};
        tablo[10] = '{LD_W,  1'b1, 11, 22, 0,             0,   0, 0, 0, 1, 2};
        tablo[11] = '{RUN,   1'b0, 0,   0, 1,             11,  9, 0, 0, 0, 0};
        tablo[12] = '{RUN,   1'b0, 0,   0, 1,             11,  9, 0, 0, 1, 2};

        // Reset
        repeat (2) @(posedge clk);
        #1;
        dort_kontrol("reset", 1'b0, 1'b0, 0, 0);
        rst_n = 1'b1;
        yurut(RUN, 1'b0, 0, 0, 0, 0, 0);

        // Command table
        for (int i = 0; i < 13; i++) begin
            exp_w[0] = tablo[i].w0; exp_x[0] = tablo[i].x0;
            exp_w[1] = tablo[i].w1; exp_x[1] = tablo[i].x1;
            yurut(tablo[i].k, tablo[i].r, tablo[i].a, tablo[i].b,
                  tablo[i].len, tablo[i].s, tablo[i].n);
        end

        // Saturation: 20 W words offered (two-word build), 18 X words offered
        yurut(CLR_W, 1'b0, 0, 0, 0, 0, 0);
        yurut(CLR_X, 1'b0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 10; j++) yurut(LD_W, 1'b1, 32'(1000 + 2 * j), 32'(1001 + 2 * j), 0, 0, 0);
        for (int j = 0; j < 18; j++) yurut(LD_X, 1'b0, 32'(2000 + j), 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            exp_w[i] = CIFT ? 32'(1000 + i) : 32'(1000 + 2 * i);
            exp_x[i] = 32'(2000 + i);
        end
        yurut(RUN, 1'b0, 0, 0, (CIFT ? 16 : 10), 0, 0);

        // Stall in the middle of a 4-pair run
        yurut(CLR_W, 1'b0, 0, 0, 0, 0, 0);
        yurut(CLR_X, 1'b0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 4; j++) begin
            yurut(LD_W, 1'b0, 32'(10 * (j + 1)), 0, 0, 0, 0);
            yurut(LD_X, 1'b0, 32'(j + 1), 0, 0, 0, 0);
            exp_w[j] = 32'(10 * (j + 1));
            exp_x[j] = 32'(j + 1);
        end
        yurut(RUN, 1'b0, 0, 0, 4, 3, 3);

        // Held basla_i with RUN: period of 7 cycles per run
        @(negedge clk);
        kontrol = RUN; basla = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 21; c++) begin
            int m;
            logic [31:0] ew, ex;
            m = ((c - 1) % 7) + 1;
            ew = (m >= 2 && m <= 5) ? exp_w[m-2] : 32'd0;
            ex = (m >= 2 && m <= 5) ? exp_x[m-2] : 32'd0;
            dort_kontrol($sformatf("held c%0d", c), m == 1, m == 6, ew, ex);
            if (c == 21) basla = 1'b0;
            @(posedge clk); #1;
        end
        for (int c = 0; c < 3; c++) begin
            dort_kontrol($sformatf("held idle c%0d", c), 1'b0, 1'b0, 0, 0);
            @(posedge clk); #1;
        end

        // Reset in the middle of a run aborts it and empties the pointers
        @(negedge clk);
        kontrol = RUN; basla = 1'b1;
        @(posedge clk); #1;
        basla = 1'b0;
        dort_kontrol("abort c1", 1'b1, 1'b0, 0, 0);
        @(posedge clk); #1;
        dort_kontrol("abort c2", 1'b0, 1'b0, 10, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        dort_kontrol("abort rst", 1'b0, 1'b0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            dort_kontrol($sformatf("abort after c%0d", c), 1'b0, 1'b0, 0, 0);
            @(posedge clk); #1;
        end
        yurut(RUN, 1'b0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
